fm_arbiter: RTL and testbench

//  Responder side of arbiter_if. Serves read/write requests from the conv and pool modules.

---
 rtl/fm_arbiter_if.sv | 30 +++
 rtl/fm_arbiter.sv | 117 +++++++++++
 tb/tb_fm_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fm_arbiter_if.sv
// Per-client request/response bundle between a conv or pool engine and the feature-map arbiter.
// The requester holds req plus its coordinate (and write data) until the matching ready pulse.
interface fm_arbiter_if #(
   parameter int COORD_BITS = 6,
   parameter int DW         = 32
);
   typedef struct packed {
      logic [COORD_BITS-1:0] y;
      logic [COORD_BITS-1:0] x;
   } vec2_t;

   vec2_t           coord_get;
   logic            read_req;
   logic            read_ready;
   logic [DW-1:0]   data_out;
   vec2_t           coord_wtr;
   logic [DW-1:0]   data_in;
   logic            write_req;
   logic            write_ready;

   modport master (
      output coord_get, read_req, coord_wtr, data_in, write_req,
      input  read_ready, data_out, write_ready
   );

   modport slave (
      input  coord_get, read_req, coord_wtr, data_in, write_req,
      output read_ready, data_out, write_ready
   );
endinterface

// File: rtl/fm_arbiter.sv
// Serialises conv/pool accesses onto one single-port feature-map RAM; writes beat reads, round-robin per class.
// write_ready 1 cycle and read_ready 3 cycles after the grant; requests simply wait while another access is in flight.
module fm_arbiter #(
   parameter  int COORD_BITS       = 6,
   parameter  int CHANNELS         = 4,
   parameter  int BITS_PER_CHANNEL = 8,
   parameter  int FM_W             = 32,
   parameter  int FM_H             = 32,
   localparam int DW               = CHANNELS * BITS_PER_CHANNEL,
   localparam int AW               = $clog2(FM_W * FM_H)
) (
   input  logic          clk,
   input  logic          rst,
   fm_arbiter_if.slave   conv,
   fm_arbiter_if.slave   pool,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          oob_err
);
   localparam logic [COORD_BITS:0] W_LIM = (COORD_BITS + 1)'(FM_W);
   localparam logic [COORD_BITS:0] H_LIM = (COORD_BITS + 1)'(FM_H);

   typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_RESP} state_t;

   state_t                state_q, state_d;
   logic                  rr_q, gnt_q, gnt_d, oob_q;
   logic                  load, sel_wr, sel_oob;
   logic [COORD_BITS-1:0] sel_x, sel_y;
   logic [DW-1:0]         sel_data, wdata_q;
   logic [AW-1:0]         sel_addr, addr_q;

   // Client index: 0 = conv, 1 = pool. On contention the client opposite rr wins.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      load    = 1'b0;
      sel_wr  = 1'b0;
      case (state_q)
         IDLE: begin
            if (conv.write_req || pool.write_req) begin
               state_d = WRITE;
               load    = 1'b1;
               sel_wr  = 1'b1;
               gnt_d   = (conv.write_req && pool.write_req) ? !rr_q : pool.write_req;
            end else if (conv.read_req || pool.read_req) begin
               state_d = RD_ISSUE;
               load    = 1'b1;
               gnt_d   = (conv.read_req && pool.read_req) ? !rr_q : pool.read_req;
            end
         end
         WRITE:    state_d = IDLE;
         RD_ISSUE: state_d = RD_WAIT;
         RD_WAIT:  state_d = RD_RESP;
         RD_RESP:  state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      sel_x    = '0;
      sel_y    = '0;
      sel_data = '0;
      if (sel_wr) begin
         sel_x    = gnt_d ? pool.coord_wtr.x : conv.coord_wtr.x;
         sel_y    = gnt_d ? pool.coord_wtr.y : conv.coord_wtr.y;
         sel_data = gnt_d ? pool.data_in    : conv.data_in;
      end else begin
         sel_x    = gnt_d ? pool.coord_get.x : conv.coord_get.x;
         sel_y    = gnt_d ? pool.coord_get.y : conv.coord_get.y;
      end
      sel_oob  = ({1'b0, sel_x} >= W_LIM) || ({1'b0, sel_y} >= H_LIM);
      sel_addr = AW'(sel_y) * AW'(FM_W) + AW'(sel_x);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         rr_q          <= 1'b0;
         gnt_q         <= 1'b0;
         oob_q         <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         oob_err       <= 1'b0;
         conv.data_out <= '0;
         pool.data_out <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            gnt_q   <= gnt_d;
            rr_q    <= gnt_d;
            oob_q   <= sel_oob;
            addr_q  <= sel_addr;
            wdata_q <= sel_data;
            if (sel_oob) oob_err <= 1'b1;
         end
         // RAM data is valid in the cycle after the issue; out-of-range reads return zero.
         if (state_q == RD_WAIT) begin
            if (gnt_q) pool.data_out <= oob_q ? '0 : mem_rdata;
            else       conv.data_out <= oob_q ? '0 : mem_rdata;
         end
      end
   end

   // An out-of-range access walks the same states with the RAM left disabled.
   assign mem_en    = ((state_q == WRITE) || (state_q == RD_ISSUE)) && !oob_q;
   assign mem_we    = (state_q == WRITE) && !oob_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   assign conv.write_ready = (state_q == WRITE)   && !gnt_q;
   assign pool.write_ready = (state_q == WRITE)   &&  gnt_q;
   assign conv.read_ready  = (state_q == RD_RESP) && !gnt_q;
   assign pool.read_ready  = (state_q == RD_RESP) &&  gnt_q;
endmodule

// File: tb/tb_fm_arbiter.sv
// Directed and randomized checks of fm_arbiter against a behavioural feature-map model.
module tb_fm_arbiter;
   localparam int CB = 6;
   localparam int DW = 32;
   localparam int AW = 10;
   localparam int FW = 32;
   localparam int FH = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fm_arbiter_if #(.COORD_BITS(CB), .DW(DW)) conv_if ();
   fm_arbiter_if #(.COORD_BITS(CB), .DW(DW)) pool_if ();

   logic          mem_en, mem_we, oob_err;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   fm_arbiter #(.COORD_BITS(CB), .CHANNELS(4), .BITS_PER_CHANNEL(8), .FM_W(FW), .FM_H(FH)) dut (
      .clk(clk), .rst(rst), .conv(conv_if), .pool(pool_if),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .oob_err(oob_err)
   );

   // Single-port synchronous RAM seen by the arbiter.
   logic [DW-1:0] ram [0:1023];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end
   end

   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_client(input int c, input logic rd, input logic wr,
                               input int x, input int y, input logic [DW-1:0] d);
      logic [CB-1:0] xv, yv;
      xv = CB'(x);
      yv = CB'(y);
      if (c == 0) begin
         conv_if.read_req = rd; conv_if.write_req = wr;
         conv_if.coord_get = {yv, xv}; conv_if.coord_wtr = {yv, xv}; conv_if.data_in = d;
      end else begin
         pool_if.read_req = rd; pool_if.write_req = wr;
         pool_if.coord_get = {yv, xv}; pool_if.coord_wtr = {yv, xv}; pool_if.data_in = d;
      end
   endtask

   function automatic logic get_wr_rdy(input int c);
      return (c == 0) ? conv_if.write_ready : pool_if.write_ready;
   endfunction
   function automatic logic get_rd_rdy(input int c);
      return (c == 0) ? conv_if.read_ready : pool_if.read_ready;
   endfunction
   function automatic logic [DW-1:0] get_dout(input int c);
      return (c == 0) ? conv_if.data_out : pool_if.data_out;
   endfunction

   // Cycle index (1 = first cycle after the grant edge) of the first ready pulse per client.
   int cw_at, cr_at, pw_at, pr_at;
   logic [DW-1:0] cr_dat, pr_dat;

   task automatic run_pulses(input int n);
      bit dc, dp;
      cw_at = -1; cr_at = -1; pw_at = -1; pr_at = -1;
      dc = 0; dp = 0;
      for (int c = 1; c <= n; c++) begin
         @(posedge clk); #1;
         if (dc) begin conv_if.read_req = 0; conv_if.write_req = 0; dc = 0; end
         if (dp) begin pool_if.read_req = 0; pool_if.write_req = 0; dp = 0; end
         @(negedge clk);
         if (conv_if.write_ready && cw_at < 0) cw_at = c;
         if (pool_if.write_ready && pw_at < 0) pw_at = c;
         if (conv_if.read_ready && cr_at < 0) begin cr_at = c; cr_dat = conv_if.data_out; end
         if (pool_if.read_ready && pr_at < 0) begin pr_at = c; pr_dat = pool_if.data_out; end
         if (conv_if.write_ready || conv_if.read_ready) dc = 1;
         if (pool_if.write_ready || pool_if.read_ready) dp = 1;
      end
      @(posedge clk); #1;
      if (dc) begin conv_if.read_req = 0; conv_if.write_req = 0; end
      if (dp) begin pool_if.read_req = 0; pool_if.write_req = 0; end
   endtask

   localparam logic [DW-1:0] A_DAT = 32'hA5A5_1234;
   localparam logic [DW-1:0] B_DAT = 32'h0BB0_5678;
   localparam logic [DW-1:0] C_DAT = 32'hC0C0_9ABC;

   // Reference model: expected feature-map contents for the randomized phase.
   logic [DW-1:0] ref_mem [0:1023];
   bit            busy[2], is_wr[2], done_now[2];
   int            xs[2], ys[2], wait_cyc[2];
   logic [DW-1:0] wd[2], w3_dat, exp_dat;
   int            nw, npr, n_wr, n_rd, nrdy;
   bit            cw_seen, pr_seen, seen_oob, ok;

   initial begin
      for (int i = 0; i < 1024; i++) begin ram[i] = '0; ref_mem[i] = '0; end
      rst = 1'b1;
      drive_client(0, 0, 0, 0, 0, '0);
      drive_client(1, 0, 0, 0, 0, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mem_en", mem_en, 0);
      check("rst_readys", {conv_if.read_ready, conv_if.write_ready,
                           pool_if.read_ready, pool_if.write_ready}, 0);
      check("rst_dout", {conv_if.data_out, pool_if.data_out}, 0);
      check("rst_oob", oob_err, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Write (3,5)=A then read it back.
      drive_client(0, 0, 1, 3, 5, A_DAT);
      @(posedge clk); @(negedge clk);
      check("t1_wr_ready", conv_if.write_ready, 1);
      check("t1_wr_en", {mem_en, mem_we}, 2'b11);
      check("t1_wr_addr", mem_addr, 163);
      check("t1_wr_data", mem_wdata, A_DAT);
      @(posedge clk); #1;
      drive_client(0, 1, 0, 3, 5, '0);
      @(posedge clk); @(negedge clk);
      check("t1_rd_issue", {mem_en, mem_we, conv_if.read_ready}, 3'b100);
      check("t1_rd_addr", mem_addr, 163);
      @(posedge clk); @(negedge clk);
      check("t1_rd_wait", conv_if.read_ready, 0);
      @(posedge clk); @(negedge clk);
      check("t1_rd_ready", conv_if.read_ready, 1);
      check("t1_rd_data", conv_if.data_out, A_DAT);
      @(posedge clk); #1;
      drive_client(0, 0, 0, 0, 0, '0);

      // Simultaneous writes with rr=conv: pool first, then conv.
      drive_client(0, 0, 1, 1, 2, B_DAT);
      drive_client(1, 0, 1, 2, 2, C_DAT);
      run_pulses(6);
      check("t2_pool_wr_at", pw_at, 1);
      check("t2_conv_wr_at", cw_at, 3);

      // rr now points at conv, so simultaneous reads again go to pool first.
      drive_client(0, 1, 0, 1, 2, '0);
      drive_client(1, 1, 0, 2, 2, '0);
      run_pulses(9);
      check("t2_pool_rd_at", pr_at, 3);
      check("t2_pool_rd_dat", pr_dat, C_DAT);
      check("t2_conv_rd_at", cr_at, 7);
      check("t2_conv_rd_dat", cr_dat, B_DAT);

      // Pool read held while conv issues three back-to-back writes.
      nw = 0; npr = 0; cw_seen = 0; pr_seen = 0; w3_dat = 32'h3333_0003;
      drive_client(0, 0, 1, 0, 3, 32'h3333_0001);
      drive_client(1, 1, 0, 2, 3, '0);
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (cw_seen) begin
            if (nw == 1)      drive_client(0, 0, 1, 1, 3, 32'h3333_0002);
            else if (nw == 2) drive_client(0, 0, 1, 2, 3, w3_dat);
            else              drive_client(0, 0, 0, 0, 0, '0);
         end
         if (pr_seen) drive_client(1, 0, 0, 0, 0, '0);
         cw_seen = 0; pr_seen = 0;
         @(negedge clk);
         if (conv_if.write_ready) begin
            nw++; cw_seen = 1;
            check("t3_wr_cycle", c, 2 * nw - 1);
         end
         if (pool_if.read_ready) begin
            npr++; pr_seen = 1;
            check("t3_rd_cycle", c, 9);
            check("t3_rd_data", pool_if.data_out, w3_dat);
         end
      end
      check("t3_wr_count", nw, 3);
      check("t3_rd_count", npr, 1);

      // Out-of-range read.
      @(posedge clk); #1;
      drive_client(1, 1, 0, FW, 0, '0);
      @(posedge clk); @(negedge clk);
      check("t4_no_mem_en", mem_en, 0);
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      check("t4_rd_ready", pool_if.read_ready, 1);
      check("t4_rd_data", pool_if.data_out, 0);
      check("t4_oob_err", oob_err, 1);
      @(posedge clk); #1;
      drive_client(1, 0, 0, 0, 0, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("t4_oob_sticky", oob_err, 1);

      // Reset while in RD_WAIT aborts the read; the held request completes afterwards.
      @(posedge clk); #1;
      drive_client(0, 1, 0, 3, 5, '0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("t5_rst_dout", conv_if.data_out, 0);
      check("t5_rst_outs", {conv_if.read_ready, mem_en, oob_err}, 0);
      @(posedge clk); @(negedge clk);
      check("t5_rst_no_ready", conv_if.read_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_pulses(6);
      check("t5_rd_at", cr_at, 3);
      check("t5_rd_data", cr_dat, A_DAT);

      // Randomized traffic against the reference model (rows 8..9, unused so far).
      n_wr = 0; n_rd = 0; seen_oob = 0;
      for (int c = 0; c < 2; c++) begin busy[c] = 0; done_now[c] = 0; end
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(posedge clk); #1;
         for (int c = 0; c < 2; c++) begin
            if (done_now[c]) begin
               drive_client(c, 0, 0, 0, 0, '0);
               done_now[c] = 0;
               busy[c] = 0;
            end else if (!busy[c] && cyc < 1400 && $urandom_range(0, 3) == 0) begin
               is_wr[c]    = ($urandom_range(0, 1) == 1);
               xs[c]       = ($urandom_range(0, 9) == 0) ? FW + $urandom_range(0, 1) : $urandom_range(0, 3);
               ys[c]       = 8 + $urandom_range(0, 1);
               wd[c]       = $urandom;
               busy[c]     = 1;
               wait_cyc[c] = 0;
               drive_client(c, !is_wr[c], is_wr[c], xs[c], ys[c], wd[c]);
            end
         end
         @(negedge clk);
         nrdy = 0;
         for (int c = 0; c < 2; c++) nrdy += int'(get_wr_rdy(c)) + int'(get_rd_rdy(c));
         if (nrdy > 0) check("rnd_one_pulse", nrdy, 1);
         for (int c = 0; c < 2; c++) begin
            if (busy[c]) wait_cyc[c]++;
            if (get_wr_rdy(c) || get_rd_rdy(c)) begin
               ok = busy[c] && !done_now[c] &&
                    (is_wr[c] ? (get_wr_rdy(c) && !get_rd_rdy(c)) : (get_rd_rdy(c) && !get_wr_rdy(c)));
               check("rnd_expected_pulse", ok, 1);
               if (xs[c] >= FW) seen_oob = 1;
               if (get_wr_rdy(c)) begin
                  n_wr++;
                  if (xs[c] < FW && ys[c] < FH) ref_mem[ys[c] * FW + xs[c]] = wd[c];
               end else begin
                  n_rd++;
                  exp_dat = (xs[c] < FW && ys[c] < FH) ? ref_mem[ys[c] * FW + xs[c]] : '0;
                  check("rnd_rd_data", get_dout(c), exp_dat);
               end
               done_now[c] = 1;
            end else if (busy[c] && !done_now[c] && wait_cyc[c] > 60) begin
               check("rnd_timeout", wait_cyc[c], 0);
               done_now[c] = 1;
            end
         end
      end
      check("rnd_drained", {busy[0], busy[1]}, 0);
      check("rnd_oob_err", oob_err, seen_oob);
      check("rnd_some_writes", n_wr > 20, 1);
      check("rnd_some_reads", n_rd > 20, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
